// File: rtl/pointer_tracker.sv
// Cursor tracker: accumulates USB mouse deltas, applies them once per frame, emits click events.
// Latency: position updates on the clock after a frame_sync fall is seen; btn_state/click one cycle after report.
// Backpressure: one click event is held until click_ready; a new press while held is dropped and flagged.
//
// Ports:
//   Clk, Reset          - system clock, asynchronous active-high reset
//   report_valid/dx/dy  - one-cycle mouse report pulse with signed 8-bit deltas (dy positive = down)
//   report_btn          - button levels carried by the report (1 = pressed)
//   frame_sync          - vsync level, synchronous to Clk; pending motion is applied after its falling edge
//   pos_x, pos_y        - clamped cursor position
//   btn_state           - button levels from the most recent report
//   click_valid/ready   - valid/ready handshake for click events
//   click_x/y/btn       - position at press time and one-hot pressed button
//   click_overrun       - sticky flag: a press was dropped because an event was still held
//
// Build option: define POINTER_TRACKER_ACCEL_EN to double any report delta with |delta| >= ACCEL_THRESH.

module pointer_tracker #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int POS_W        = 10,
   parameter int NUM_BTN      = 4,
   parameter int ACCEL_THRESH = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               report_valid,
   input  logic [7:0]         report_dx,
   input  logic [7:0]         report_dy,
   input  logic [NUM_BTN-1:0] report_btn,
   input  logic               frame_sync,
   output logic [POS_W-1:0]   pos_x,
   output logic [POS_W-1:0]   pos_y,
   output logic [NUM_BTN-1:0] btn_state,
   output logic               click_valid,
   input  logic               click_ready,
   output logic [POS_W-1:0]   click_x,
   output logic [POS_W-1:0]   click_y,
   output logic [NUM_BTN-1:0] click_btn,
   output logic               click_overrun
);

   // Position math is done three bits wider than the position so that a
   // full-scale pending sum can push the result below zero or past the edge
   // without wrapping before the clamp.
   localparam int SW = POS_W + 3;
   localparam logic signed [SW-1:0] MAX_X  = SW'(SCREEN_W - 1);
   localparam logic signed [SW-1:0] MAX_Y  = SW'(SCREEN_H - 1);
   localparam logic [POS_W-1:0]     HOME_X = POS_W'(SCREEN_W / 2);
   localparam logic [POS_W-1:0]     HOME_Y = POS_W'(SCREEN_H / 2);
   localparam logic signed [12:0]   SAT_HI = 13'sd2047;
   localparam logic signed [12:0]   SAT_LO = -13'sd2048;
`ifdef POINTER_TRACKER_ACCEL_EN
   localparam logic [9:0]           ACCEL_MAG = 10'(ACCEL_THRESH);
`endif

   logic                     fs_q;
   logic                     apply;
   logic signed [11:0]       pend_x, pend_y;
   logic signed [11:0]       pend_x_nxt, pend_y_nxt;
   logic [POS_W-1:0]         pos_x_nxt, pos_y_nxt;
   logic signed [9:0]        dx_s, dy_s;
   logic [NUM_BTN-1:0]       rise;
   logic [NUM_BTN-1:0]       press_oh;
   logic                     press;
   logic                     accept;

   // Sign-extend a report delta; optionally double large moves.
   function automatic logic signed [9:0] scale_delta(input logic [7:0] d);
      logic signed [9:0] ext;
`ifdef POINTER_TRACKER_ACCEL_EN
      logic [9:0] mag;
`endif
      ext = {{2{d[7]}}, d};
`ifdef POINTER_TRACKER_ACCEL_EN
      mag = ext[9] ? -ext : ext;
      if (mag >= ACCEL_MAG) ext = ext <<< 1;
`endif
      return ext;
   endfunction

   // 12-bit saturating accumulate.
   function automatic logic signed [11:0] accum(input logic signed [11:0] p,
                                                input logic signed [9:0]  d);
      logic signed [12:0] s;
      s = $signed({p[11], p}) + $signed({{3{d[9]}}, d});
      if (s > SAT_HI)      accum = 12'sh7ff;
      else if (s < SAT_LO) accum = 12'sh800;
      else                 accum = s[11:0];
   endfunction

   // Add a pending sum to a position and clamp into 0..lim.
   function automatic logic [POS_W-1:0] apply_pos(input logic [POS_W-1:0]   pos,
                                                  input logic signed [11:0] p,
                                                  input logic signed [SW-1:0] lim);
      logic signed [SW-1:0] s;
      s = $signed({3'b000, pos}) + SW'(p);
      if (s[SW-1])      apply_pos = '0;
      else if (s > lim) apply_pos = lim[POS_W-1:0];
      else              apply_pos = s[POS_W-1:0];
   endfunction

   assign apply = fs_q & ~frame_sync;
   assign dx_s  = scale_delta(report_dx);
   assign dy_s  = scale_delta(report_dy);

   // On the apply cycle the pending sums restart from zero, so a report
   // landing in the same cycle becomes the new pending value.
   always_comb begin
      pos_x_nxt  = pos_x;
      pos_y_nxt  = pos_y;
      pend_x_nxt = pend_x;
      pend_y_nxt = pend_y;
      if (apply) begin
         pos_x_nxt  = apply_pos(pos_x, pend_x, MAX_X);
         pos_y_nxt  = apply_pos(pos_y, pend_y, MAX_Y);
         pend_x_nxt = '0;
         pend_y_nxt = '0;
      end
      if (report_valid) begin
         pend_x_nxt = accum(pend_x_nxt, dx_s);
         pend_y_nxt = accum(pend_y_nxt, dy_s);
      end
   end

   // New presses relative to the last report; isolate the lowest set bit.
   assign rise     = report_valid ? (report_btn & ~btn_state) : '0;
   assign press_oh = rise & (-rise);
   assign press    = |rise;
   assign accept   = click_valid & click_ready;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fs_q          <= 1'b0;
         pend_x        <= '0;
         pend_y        <= '0;
         pos_x         <= HOME_X;
         pos_y         <= HOME_Y;
         btn_state     <= '0;
         click_valid   <= 1'b0;
         click_x       <= '0;
         click_y       <= '0;
         click_btn     <= '0;
         click_overrun <= 1'b0;
      end else begin
         fs_q   <= frame_sync;
         pend_x <= pend_x_nxt;
         pend_y <= pend_y_nxt;
         pos_x  <= pos_x_nxt;
         pos_y  <= pos_y_nxt;
         if (report_valid) btn_state <= report_btn;

         // A slot is free when nothing is held or the held event leaves this cycle.
         if (press && (!click_valid || accept)) begin
            click_valid <= 1'b1;
            click_x     <= pos_x;
            click_y     <= pos_y;
            click_btn   <= press_oh;
         end else begin
            if (press)  click_overrun <= 1'b1;
            if (accept) click_valid   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pointer_tracker.sv
module tb_pointer_tracker;

   localparam int POS_W   = 10;
   localparam int NUM_BTN = 4;
`ifdef POINTER_TRACKER_ACCEL_EN
   localparam bit ACC = 1'b1;
`else
   localparam bit ACC = 1'b0;
`endif
   localparam int SAT_N = ACC ? 8 : 15;
   localparam int SAT_X = ACC ? 447 : 547;
   localparam int X32   = ACC ? 343 : 335;

   logic               Clk = 1'b0;
   logic               Reset;
   logic               report_valid;
   logic [7:0]         report_dx, report_dy;
   logic [NUM_BTN-1:0] report_btn;
   logic               frame_sync;
   logic [POS_W-1:0]   pos_x, pos_y;
   logic [NUM_BTN-1:0] btn_state;
   logic               click_valid, click_ready;
   logic [POS_W-1:0]   click_x, click_y;
   logic [NUM_BTN-1:0] click_btn;
   logic               click_overrun;

   typedef struct { int x; int y; } pos_exp_t;
   typedef struct { int x; int y; int btn; } click_exp_t;
   pos_exp_t   pos_q[$];
   click_exp_t click_q[$];

   int checks   = 0;
   int failures = 0;
   int last_x   = 320;
   int last_y   = 240;

   pointer_tracker dut (
      .Clk(Clk), .Reset(Reset),
      .report_valid(report_valid), .report_dx(report_dx), .report_dy(report_dy),
      .report_btn(report_btn), .frame_sync(frame_sync),
      .pos_x(pos_x), .pos_y(pos_y), .btn_state(btn_state),
      .click_valid(click_valid), .click_ready(click_ready),
      .click_x(click_x), .click_y(click_y), .click_btn(click_btn),
      .click_overrun(click_overrun)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic report(input int dx, input int dy, input logic [NUM_BTN-1:0] btn);
      report_valid = 1'b1;
      report_dx    = 8'(dx);
      report_dy    = 8'(dy);
      report_btn   = btn;
      tick();
      report_valid = 1'b0;
   endtask

   // Drive one frame_sync pulse; expected position is queued when driven and
   // compared after the apply edge. Optionally a report coincides with the apply cycle.
   task automatic frame(input int ex, input int ey, input bit co, input int cdx, input int cdy);
      pos_exp_t e;
      pos_q.push_back('{ex, ey});
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      check("pos_x_before_edge", pos_x, last_x);
      check("pos_y_before_edge", pos_y, last_y);
      if (co) begin
         report_valid = 1'b1;
         report_dx    = 8'(cdx);
         report_dy    = 8'(cdy);
      end
      tick();
      report_valid = 1'b0;
      check("pos_sb_size", pos_q.size(), 1);
      if (pos_q.size() != 0) begin
         e = pos_q.pop_front();
         check("pos_x", pos_x, e.x);
         check("pos_y", pos_y, e.y);
         last_x = e.x;
         last_y = e.y;
      end
   endtask

   task automatic press(input logic [NUM_BTN-1:0] btn, input int exp_btn);
      click_q.push_back('{last_x, last_y, exp_btn});
      report(0, 0, btn);
   endtask

   // Compare the held event against the scoreboard, then accept it.
   task automatic pop_click();
      click_exp_t e;
      check("click_sb_size", click_q.size(), 1);
      if (click_q.size() != 0) begin
         e = click_q.pop_front();
         check("click_valid_at_accept", click_valid, 1);
         check("click_x", click_x, e.x);
         check("click_y", click_y, e.y);
         check("click_btn", click_btn, e.btn);
      end
   endtask

   task automatic accept();
      pop_click();
      click_ready = 1'b1;
      tick();
      click_ready = 1'b0;
      check("click_valid_after_accept", click_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      Reset        = 1'b1;
      report_valid = 1'b0;
      report_dx    = '0;
      report_dy    = '0;
      report_btn   = '0;
      frame_sync   = 1'b0;
      click_ready  = 1'b0;
      tick();
      tick();
      check("rst_pos_x", pos_x, 320);
      check("rst_pos_y", pos_y, 240);
      check("rst_click_valid", click_valid, 0);
      check("rst_click_overrun", click_overrun, 0);
      check("rst_btn_state", btn_state, 0);
      Reset = 1'b0;
      tick();

      // Basic accumulate and apply
      report(5, -2, 4'b0000);
      report(3, 0, 4'b0000);
      frame(328, 238, 0, 0, 0);

      // Clamp to the edges, then step to (635,2), then clamp again
      for (int i = 0; i < 3; i++) report(127, -128, 4'b0000);
      frame(639, 0, 0, 0, 0);
      report(-4, 2, 4'b0000);
      frame(635, 2, 0, 0, 0);
      report(20, -10, 4'b0000);
      frame(639, 0, 0, 0, 0);

      // Empty frame is a no-op; a report on the apply cycle becomes the new pending
      frame(639, 0, 1, -3, 1);
      frame(636, 1, 0, 0, 0);

      // Pending sum saturates at +2047 before the negative moves arrive
      for (int i = 0; i < 6; i++) report(-128, 0, 4'b0000);
      frame(0, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) report(127, 0, 4'b0000);
      for (int i = 0; i < SAT_N; i++) report(-100, 0, 4'b0000);
      frame(SAT_X, 1, 0, 0, 0);

      // Move to (100,50)
      for (int i = 0; i < 6; i++) report(-128, -128, 4'b0000);
      frame(0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) report(5, 5, 4'b0000);
      for (int i = 0; i < 10; i++) report(5, 0, 4'b0000);
      frame(100, 50, 0, 0, 0);

      // Click held while not ready
      press(4'b0001, 1);
      check("btn_state_after_press", btn_state, 4'b0001);
      for (int i = 0; i < 10; i++) begin
         check("hold_click_valid", click_valid, 1);
         check("hold_click_btn", click_btn, 4'b0001);
         tick();
      end
      // Press while held: dropped, overrun set, held event intact
      report(0, 0, 4'b0011);
      check("overrun_set", click_overrun, 1);
      accept();

      // Press coincident with accept loads the new event
      report(0, 0, 4'b0000);
      press(4'b0001, 1);
      pop_click();
      click_q.push_back('{last_x, last_y, 4});
      click_ready  = 1'b1;
      report(0, 0, 4'b0101);
      click_ready  = 1'b0;
      check("coincident_click_valid", click_valid, 1);
      accept();

      // Two buttons rising together: lowest index wins
      report(0, 0, 4'b0000);
      press(4'b1010, 2);
      accept();
      check("overrun_sticky", click_overrun, 1);

      // Reset mid-operation discards pending motion and a held click
      report(50, 0, 4'b0001);
      #2 Reset = 1'b1;
      #1;
      check("midrst_click_valid", click_valid, 0);
      check("midrst_overrun", click_overrun, 0);
      check("midrst_pos_x", pos_x, 320);
      check("midrst_btn_state", btn_state, 0);
      tick();
      Reset = 1'b0;
      report_btn = 4'b0000;
      click_q.delete();
      pos_q.delete();
      last_x = 320;
      last_y = 240;
      frame(320, 240, 0, 0, 0);

      // Acceleration threshold case
      report(8, 0, 4'b0000);
      report(7, 0, 4'b0000);
      frame(X32, 240, 0, 0, 0);
      check("no_stray_click", click_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pointer_tracker.md
POINTER_TRACKER -- requirements
Module: pointer_tracker

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, horizontal pixel count; x range 0..SCREEN_W-1.
REQ-002 SHALL have parameter SCREEN_H, default 480, vertical pixel count; y range 0..SCREEN_H-1.
REQ-003 SHALL have parameter POS_W, default 10, width of position outputs; SCREEN_W, SCREEN_H <= 2^POS_W.
REQ-004 SHALL have parameter NUM_BTN, default 4, number of mouse button bits tracked.
REQ-005 SHALL have parameter ACCEL_THRESH, default 8, |delta| at or above which acceleration applies.
REQ-006 SHALL have ports, clock and reset first: Clk in 1 system clock; Reset in 1 asynchronous active-high reset.
REQ-007 SHALL have ports: report_valid in 1, one-cycle pulse marking a new USB mouse report; report_dx in 8, signed two's-complement x delta; report_dy in 8, signed y delta, positive moves down.
REQ-008 SHALL have ports: report_btn in NUM_BTN, button levels, 1 = pressed; frame_sync in 1, vsync level, synchronous to Clk.
REQ-009 SHALL have ports: pos_x out POS_W, cursor x; pos_y out POS_W, cursor y; btn_state out NUM_BTN, registered button levels.
REQ-010 SHALL have ports: click_valid out 1; click_ready in 1; click_x out POS_W; click_y out POS_W; click_btn out NUM_BTN, one-hot pressed button; click_overrun out 1, sticky.

Function
REQ-011 SHALL accumulate report_dx/report_dy into signed 12-bit pending sums on each report_valid, saturating at -2048/+2047.
REQ-012 SHALL apply pending sums to pos_x/pos_y on the cycle after a frame_sync falling edge, then clear pending sums in that same cycle.
REQ-013 SHALL, when report_valid coincides with the apply cycle, make that report's delta the new pending value and not lose it.
REQ-014 SHALL clamp new position to 0..SCREEN_W-1 and 0..SCREEN_H-1; no wrap-around.
REQ-015 SHALL perform position arithmetic at POS_W+3 signed bits before clamping.
REQ-016 SHALL register report_btn into btn_state on each report_valid; 1-cycle latency.
REQ-017 SHALL detect a press as btn_state bit 0->1 on a report; lowest-index new press wins when several rise together.
REQ-018 SHALL, on a press with click_valid low, set click_valid next cycle and capture click_x/click_y = pos_x/pos_y current at detection, and click_btn.
REQ-019 SHALL hold click_valid and click_* stable until the cycle click_valid && click_ready, then deassert click_valid next cycle.
REQ-020 SHALL, on a press while click_valid high and not being accepted that cycle, drop the event and set click_overrun.
REQ-021 SHALL, on a press in the same cycle as acceptance, load the new event; click_valid stays high.
REQ-022 SHALL clear click_overrun only by Reset.
REQ-023 SHALL treat frame_sync edges with no reports as a no-op apply; pos unchanged.

Reset
REQ-024 SHALL on Reset asynchronously set pos_x = SCREEN_W/2, pos_y = SCREEN_H/2, btn_state = 0, pending sums = 0, click_valid = 0, click_x = click_y = 0, click_btn = 0, click_overrun = 0, frame_sync history = 0.
REQ-025 SHALL, on Reset mid-operation, discard pending deltas and any held click; operation resumes on first Clk edge after Reset deasserts.

Configuration
REQ-026 SHALL use macro POINTER_TRACKER_ACCEL_EN: defined -> each report delta with |delta| >= ACCEL_THRESH is doubled before accumulation; undefined -> deltas accumulate unscaled and ACCEL_THRESH is unused.

Verification
REQ-027 SHALL cover: Reset -> pos=(320,240), click_valid=0, click_overrun=0.
REQ-028 SHALL cover: reports dx=+5,+3, dy=-2, then frame_sync fall -> pos=(328,238) one cycle after edge; unchanged before edge.
REQ-029 SHALL cover: pos=(635,2), dx=+20, dy=-10, frame -> pos=(639,0).
REQ-030 SHALL cover: report_btn 0000->0001 at pos=(100,50), click_ready=0 -> click_valid=1, click_x=100, click_y=50, click_btn=0001, held 10 cycles; click_ready=1 -> click_valid=0 next cycle.
REQ-031 SHALL cover: click pending, btn 0001->0011 press -> click_overrun=1, held event unchanged; press coincident with accept -> new event loaded, click_valid stays 1.
REQ-032 SHALL cover, with POINTER_TRACKER_ACCEL_EN: dx=+8 and dx=+7, frame from 320 -> pos_x=343; without macro -> pos_x=335.
